pe_shift_accumulator: RTL and testbench

- Sits directly downstream of the 16-lane PE adder tree.
- Consumes the tree's 8-bit signed partial sum once per cycle.
- Left-shifts each partial sum by a per-beat bit-significance amount and accumulates a fixed number of beats. This recombines low-precision bit-brick partial products into one full-precision dot product.
- Presents the result on a valid/ready output and then accepts the next job.

---
 rtl/pe_shift_accumulator.sv | 129 ++++++++++++
 tb/tb_pe_shift_accumulator.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_shift_accumulator.sv
// Shift-and-accumulate stage behind the PE adder tree.
// It recombines bit-brick partial sums into one full-precision result, which it presents on a valid/ready output.
module pe_shift_accumulator #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 24,
  parameter int SH_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3:0]              num_steps,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  pe_sum,
  input  logic [SH_W-1:0]         shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    overflow,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [4:0]       count_q, count_d;
  logic [4:0]       steps_q, steps_d;
  logic             overflow_q, overflow_d;

  logic [ACC_W-1:0] term_ext;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic [4:0]       new_steps;

  always_comb begin
    term_ext  = {{(ACC_W-IN_W){pe_sum[IN_W-1]}}, pe_sum};
    term      = term_ext << shift;
    sum       = acc_q + term;
    add_ovf   = (acc_q[ACC_W-1] == term[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    // A num_steps value of zero encodes a full 16-beat job.
    new_steps = (num_steps == 4'd0) ? 5'd16 : {1'b0, num_steps};
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    acc_out_d  = acc_out_q;
    count_d    = count_q;
    steps_d    = steps_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          steps_d    = new_steps;
          acc_d      = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          state_d    = ACCUM;
        end
      end

      ACCUM: begin
        if (in_valid) begin
          acc_d   = sum;
          count_d = count_q + 5'd1;
          if (add_ovf) begin
            overflow_d = 1'b1;
          end
          if (count_q == steps_q - 5'd1) begin
            acc_out_d = sum;
            state_d   = HOLD;
          end
        end
      end

      HOLD: begin
        // A start that coincides with the handshake begins the next job with no idle bubble.
        if (out_ready) begin
          if (start) begin
            steps_d    = new_steps;
            acc_d      = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            state_d    = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      acc_out_q  <= '0;
      count_q    <= '0;
      steps_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      acc_out_q  <= acc_out_d;
      count_q    <= count_d;
      steps_q    <= steps_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign acc_out   = acc_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pe_shift_accumulator.sv
// Directed bench for pe_shift_accumulator.
// Each scenario task drives stimulus and checks the outputs against hand-computed values.
module tb_pe_shift_accumulator;

  logic               clk;
  logic               rst;
  logic               start;
  logic [3:0]         num_steps;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  pe_sum;
  logic [3:0]         shift;
  logic               out_valid;
  logic               out_ready;
  logic [23:0]        acc_out;
  logic               overflow;
  logic               busy;

  int checks;
  int failures;

  pe_shift_accumulator #(.IN_W(8), .ACC_W(24), .SH_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_steps(num_steps),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .pe_sum(pe_sum),
    .shift(shift),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out(acc_out),
    .overflow(overflow),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [3:0] n);
    start     = 1'b1;
    num_steps = n;
    tick();
    start     = 1'b0;
  endtask

  task automatic beat(input logic signed [7:0] v, input logic [3:0] s);
    in_valid = 1'b1;
    pe_sum   = v;
    shift    = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (acc_out !== 24'd0) begin
      $display("[TB] FAIL reset_acc_out actual=%h required=%h", acc_out, 24'd0); failures++;
    end
    checks++;
    if ({out_valid, in_ready, busy, overflow} !== 4'b0000) begin
      $display("[TB] FAIL reset_flags actual=%b required=0000", {out_valid, in_ready, busy, overflow}); failures++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_job();
    out_ready = 1'b1;
    start_job(4'd4);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      $display("[TB] FAIL single_enter_accum actual=%b%b required=11", in_ready, busy); failures++;
    end
    beat(8'sd3, 4'd0);
    beat(-8'sd2, 4'd1);
    beat(8'sd5, 4'd2);
    checks++;
    if (out_valid !== 1'b0) begin
      $display("[TB] FAIL single_early_valid actual=%b required=0", out_valid); failures++;
    end
    beat(-8'sd1, 4'd3);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      $display("[TB] FAIL single_valid actual=%b%b required=10", out_valid, in_ready); failures++;
    end
    checks++;
    if (acc_out !== 24'd11 || overflow !== 1'b0) begin
      $display("[TB] FAIL single_result actual=%h/%b required=%h/0", acc_out, overflow, 24'd11); failures++;
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      $display("[TB] FAIL single_to_idle actual=%b%b required=00", out_valid, busy); failures++;
    end
  endtask

  task automatic test_stall_backpressure();
    out_ready = 1'b0;
    start_job(4'd2);
    beat(8'sd127, 4'd0);
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc_out !== 24'd11) begin
      $display("[TB] FAIL stall_hold actual=%b%b/%h required=10/%h", in_ready, out_valid, acc_out, 24'd11); failures++;
    end
    beat(8'sd127, 4'd0);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 24'd254) begin
      $display("[TB] FAIL stall_result actual=%b/%h required=1/%h", out_valid, acc_out, 24'd254); failures++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== 24'd254) begin
        $display("[TB] FAIL backpressure_hold cycle=%0d actual=%b%b/%h required=10/%h",
                 i, out_valid, in_ready, acc_out, 24'd254);
        failures++;
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      $display("[TB] FAIL backpressure_release actual=%b%b required=00", out_valid, busy); failures++;
    end
  endtask

  task automatic test_sixteen_beats();
    out_ready = 1'b0;
    start_job(4'd0);
    for (int i = 0; i < 15; i++) beat(-8'sd128, 4'd0);
    checks++;
    if (out_valid !== 1'b0) begin
      $display("[TB] FAIL sixteen_early_valid actual=%b required=0", out_valid); failures++;
    end
    beat(-8'sd128, 4'd0);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 24'hFFF800 || overflow !== 1'b0) begin
      $display("[TB] FAIL sixteen_result actual=%b/%h/%b required=1/fff800/0", out_valid, acc_out, overflow); failures++;
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    start_job(4'd0);
    for (int i = 0; i < 16; i++) beat(-8'sd128, 4'd15);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 24'h000000 || overflow !== 1'b1) begin
      $display("[TB] FAIL overflow_result actual=%b/%h/%b required=1/000000/1", out_valid, acc_out, overflow); failures++;
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (overflow !== 1'b1 || busy !== 1'b0) begin
      $display("[TB] FAIL overflow_sticky_idle actual=%b%b required=10", overflow, busy); failures++;
    end
    start_job(4'd1);
    checks++;
    if (overflow !== 1'b0 || in_ready !== 1'b1) begin
      $display("[TB] FAIL overflow_clear_on_start actual=%b%b required=01", overflow, in_ready); failures++;
    end
    beat(8'sd1, 4'd0);
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    start_job(4'd1);
    beat(-8'sd3, 4'd2);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 24'hFFFFF4) begin
      $display("[TB] FAIL b2b_first actual=%b/%h required=1/fffff4", out_valid, acc_out); failures++;
    end
    start     = 1'b1;
    num_steps = 4'd3;
    tick();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== 24'hFFFFF4) begin
      $display("[TB] FAIL b2b_start_ignored actual=%b%b/%h required=10/fffff4", out_valid, in_ready, acc_out); failures++;
    end
    out_ready = 1'b1;
    num_steps = 4'd1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      $display("[TB] FAIL b2b_enter_accum actual=%b%b%b required=101", in_ready, out_valid, busy); failures++;
    end
    beat(8'sd7, 4'd4);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 24'd112) begin
      $display("[TB] FAIL b2b_second actual=%b/%h required=1/%h", out_valid, acc_out, 24'd112); failures++;
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_job();
    bit seen_valid;
    out_ready = 1'b1;
    start_job(4'd4);
    beat(8'sd9, 4'd0);
    beat(8'sd9, 4'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, out_valid, in_ready, overflow} !== 4'b0000 || acc_out !== 24'd0) begin
      $display("[TB] FAIL midjob_reset actual=%b/%h required=0000/000000",
               {busy, out_valid, in_ready, overflow}, acc_out);
      failures++;
    end
    seen_valid = 1'b0;
    in_valid   = 1'b1;
    pe_sum     = 8'sd9;
    shift      = 4'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b0) seen_valid = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (seen_valid !== 1'b0) begin
      $display("[TB] FAIL midjob_no_output actual=%b required=0", seen_valid); failures++;
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    num_steps = 4'd0;
    in_valid  = 1'b0;
    pe_sum    = '0;
    shift     = '0;
    out_ready = 1'b0;
    test_reset();
    test_single_job();
    test_stall_backpressure();
    test_sixteen_beats();
    test_overflow();
    test_back_to_back();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
